// File: rtl/axi_req_arbiter_if.sv
// Single-beat AXI3 bus bundle shared by the CPU-side arbiter (master) and the fabric (slave).
interface axi_req_arbiter_if;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_req_arbiter.sv
// Shares one AXI master port between the I-side and D-side SRAM-like request/ack interfaces,
// one single-beat transaction in flight at a time.
module axi_req_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        data_wstrb,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  axi_req_arbiter_if.master axi
);
  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B} arbStateT;

  arbStateT          state, stateNext;
  logic [ID_W-1:0]   reqId;
  logic [ADDR_W-1:0] reqAddr;
  logic [2:0]        reqSize;
  logic [DATA_W-1:0] reqWdata;
  logic [STRB_W-1:0] reqWstrb;
  logic [DATA_W-1:0] rdataQ;
  logic              awDone, wDone, awDoneNext, wDoneNext;
  logic              lastD;
  logic              instOkQ, dataOkQ;
  logic              grantI, grantD;
  logic              arvalidC, rreadyC, awvalidC, wvalidC, breadyC;
  logic              rHs, bHs;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  // Next state, grant and bus handshakes; no grant in the data_ok cycle
  always_comb begin
    stateNext  = state;
    awDoneNext = awDone;
    wDoneNext  = wDone;
    grantI     = 1'b0;
    grantD     = 1'b0;
    arvalidC   = 1'b0;
    rreadyC    = 1'b0;
    awvalidC   = 1'b0;
    wvalidC    = 1'b0;
    breadyC    = 1'b0;
    case (state)
      IDLE: begin
        if (!instOkQ && !dataOkQ) begin
          grantI = inst_req && (!data_req || lastD);
          grantD = data_req && !grantI;
          if (grantI)      stateNext = AR;
          else if (grantD) stateNext = data_wr ? AW_W : AR;
        end
      end
      AR: begin
        arvalidC = 1'b1;
        if (axi.arready) stateNext = R;
      end
      R: begin
        rreadyC = 1'b1;
        if (axi.rvalid) stateNext = IDLE;
      end
      AW_W: begin
        awvalidC   = !awDone;
        wvalidC    = !wDone;
        awDoneNext = awDone || axi.awready;
        wDoneNext  = wDone || axi.wready;
        if (awDoneNext && wDoneNext) begin
          stateNext  = B;
          awDoneNext = 1'b0;
          wDoneNext  = 1'b0;
        end
      end
      B: begin
        breadyC = 1'b1;
        if (axi.bvalid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign rHs = rreadyC && axi.rvalid;
  assign bHs = breadyC && axi.bvalid;

  // Request capture, write-handshake flags, read data and registered acks
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reqId    <= '0;
      reqAddr  <= '0;
      reqSize  <= '0;
      reqWdata <= '0;
      reqWstrb <= '0;
      rdataQ   <= '0;
      awDone   <= 1'b0;
      wDone    <= 1'b0;
      lastD    <= 1'b1;
      instOkQ  <= 1'b0;
      dataOkQ  <= 1'b0;
    end else begin
      if (grantI) begin
        reqId   <= INST_ID;
        reqAddr <= inst_addr;
        reqSize <= 3'd2;
        lastD   <= 1'b0;
      end else if (grantD) begin
        reqId    <= DATA_ID;
        reqAddr  <= data_addr;
        reqSize  <= 3'(data_size);
        reqWdata <= data_wdata;
        reqWstrb <= data_wstrb;
        lastD    <= 1'b1;
      end
      awDone  <= awDoneNext;
      wDone   <= wDoneNext;
      instOkQ <= rHs && (axi.rid == INST_ID);
      dataOkQ <= (rHs && (axi.rid == DATA_ID)) || bHs;
      if (rHs) rdataQ <= axi.rdata;
    end
  end

  assign inst_addr_ok = grantI;
  assign data_addr_ok = grantD;
  assign inst_data_ok = instOkQ;
  assign data_data_ok = dataOkQ;
  assign inst_rdata   = rdataQ;
  assign data_rdata   = rdataQ;

  assign axi.arid    = reqId;
  assign axi.araddr  = reqAddr;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = reqSize;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalidC;
  assign axi.rready  = rreadyC;
  assign axi.awid    = reqId;
  assign axi.awaddr  = reqAddr;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = reqSize;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalidC;
  assign axi.wid     = DATA_ID;
  assign axi.wdata   = reqWdata;
  assign axi.wstrb   = reqWstrb;
  assign axi.wlast   = wvalidC;
  assign axi.wvalid  = wvalidC;
  assign axi.bready  = breadyC;
endmodule
